icache_unit: RTL and testbench
==============================

# icache_unit

Direct-mapped, read-only instruction cache between the program counter unit and the instruction memory. Each cycle it takes the PC value as a byte address and returns the 32-bit instruction on a hit. On a miss it raises `BUSYWAIT`, which stalls the PC, and fills one 16-byte block from memory through a `MEM_READ`/`MEM_BUSYWAIT` handshake.

## Interface
- Parameters: none. Geometry is fixed: 8 lines × 16 bytes (4 words), 10-bit byte address.
- `CLK` in 1: clock; all state updates on posedge.
- `RESET` in 1: asynchronous, active-high; clears all valid bits and returns the FSM to IDLE.
- `ADDRESS` in 10: instruction byte address (PC[9:0]).
  - Fields: tag = [9:7], index = [6:4], word = [3:2].
  - [1:0] are ignored.
- `INSTRUCTION` out 32: selected word of the addressed line.
- `BUSYWAIT` out 1: high while the instruction is not yet valid; the PC must hold.
- `MEM_READ` out 1: block read request to instruction memory.
- `MEM_ADDRESS` out 6: block address {tag, index}.
- `MEM_READDATA` in 128: block data.
  - Word 0 = [31:0], word 3 = [127:96].
- `MEM_BUSYWAIT` in 1: memory busy; data is valid in any cycle where it is low while `MEM_READ` is high.

## Operation
- Storage per line: valid (1), tag (3), data (128).
- Hit = valid[index] & (tag[index] == ADDRESS[9:7]). Evaluated combinationally.
- `INSTRUCTION` = data[index] word selected by ADDRESS[3:2]. It is combinational in every state; its value is meaningful only when `BUSYWAIT` = 0.
- FSM states: IDLE, READ_MEM, UPDATE.
- IDLE:
  - `BUSYWAIT` = !hit. `MEM_READ` = 0.
  - On a miss, the next posedge latches {tag, index} into a miss register and moves to READ_MEM.
  - On a hit, stay in IDLE.
- READ_MEM:
  - `MEM_READ` = 1. `MEM_ADDRESS` = latched {tag, index}. `BUSYWAIT` = 1.
  - At a posedge with `MEM_BUSYWAIT` = 0: write `MEM_READDATA` into the latched index, set its tag, set valid = 1, and go to UPDATE.
  - Otherwise stay in READ_MEM.
- UPDATE:
  - `MEM_READ` = 0. `BUSYWAIT` = 1.
  - Next posedge goes to IDLE unconditionally.
  - In IDLE the hit resolves and `BUSYWAIT` drops.
- The fill uses only the latched address. An `ADDRESS` change during a miss cannot corrupt the fill; it is re-evaluated in IDLE.
- `MEM_ADDRESS` = latched {tag, index} in every state; it is 0 after reset.
- No write path. No replacement policy beyond direct-mapped overwrite.
- Reset values:
  - All valid = 0, state = IDLE, miss register = 0, `MEM_READ` = 0.
  - While `RESET` is high, `BUSYWAIT` is forced to 0.
  - Tag and data arrays are not required to reset.
- Reset mid-miss: the FSM goes to IDLE immediately (asynchronous) and `MEM_READ` falls without waiting for a clock edge. The line is not written. The first access after release misses.

## Timing
- Hit: zero-cycle latency; `INSTRUCTION` and `BUSYWAIT` = 0 are valid in the same cycle the address is presented.
- Miss with memory busy for L cycles (`MEM_BUSYWAIT` high for L READ_MEM cycles, then low for one):
  - `BUSYWAIT` high for exactly L+3 cycles: 1 IDLE + (L+1) READ_MEM + 1 UPDATE.
  - The instruction is valid in the following cycle.
- Memory with L = 0 (`MEM_BUSYWAIT` never asserted): penalty = 3 cycles.
- `MEM_READ` stays high continuously from entry to READ_MEM until the accepting edge. It never pulses twice per miss.
- A hit in the cycle directly after UPDATE→IDLE is mandatory for the filled address.
- Consecutive misses to different lines are serialized; each costs the full penalty.

## Test plan
- Reset then fetch `ADDRESS` = 0x000, memory L = 4:
  - `BUSYWAIT` high 7 cycles.
  - `MEM_READ` high 5 cycles with `MEM_ADDRESS` = 0x00.
  - Then `INSTRUCTION` = `MEM_READDATA`[31:0], `BUSYWAIT` = 0.
- After that fill, step `ADDRESS` 0x004, 0x008, 0x00C:
  - Hits every cycle, `BUSYWAIT` = 0.
  - `INSTRUCTION` = words 1, 2, 3.
  - `MEM_READ` never asserted.
- Conflict: fill 0x000, then 0x080 (same index 0, tag 1), then 0x000 again:
  - Three misses, each L+3 cycles.
  - `MEM_ADDRESS` = 0x00, 0x08, 0x00.
- Change `ADDRESS` from 0x010 to 0x020 while in READ_MEM:
  - Line 1 is filled with tag 0.
  - The FSM then misses on 0x020 (`MEM_ADDRESS` = 0x02).
- Assert `RESET` two cycles into READ_MEM:
  - `MEM_READ` and `BUSYWAIT` fall within the same cycle, without waiting for a clock edge.
  - After release, 0x000 misses again.
- L = 0 memory: a miss on 0x3F0 gives `BUSYWAIT` high for exactly 3 cycles and `MEM_ADDRESS` = 0x3F.

Source files
------------

// File: rtl/icache_unit_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: none; wires only.
// Backpressure: BUSYWAIT stalls the PC; MEM_BUSYWAIT stalls the block fill.
//
// master: PC unit + instruction memory side (drives ADDRESS, MEM_READDATA, MEM_BUSYWAIT)
// slave : cache side (drives INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS)
interface icache_unit_if;
    logic [9:0]   ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport master (
        output ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );

    modport slave (
        input  ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
    );
endinterface

// File: rtl/icache_unit.sv
// Direct-mapped read-only instruction cache, 8 lines x 16 bytes, 10-bit byte address.
// Latency: hit is combinational (0 cycles); miss costs L+3 cycles for memory latency L.
// Backpressure: BUSYWAIT holds the PC during a miss; the fill waits on MEM_BUSYWAIT.
//
// Ports: CLK, RESET (async, active-high); bus (slave modport) carries the fetch
// address/instruction/stall and the block-read handshake to instruction memory.
module icache_unit (
    input  logic          CLK,
    input  logic          RESET,
    icache_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        READ_MEM = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     miss_q, miss_d;      // latched {tag, index} of the missing block
    logic [7:0]     valid_q, valid_d;
    logic [2:0]     tag_q  [8];
    logic [2:0]     tag_d  [8];
    logic [127:0]   data_q [8];
    logic [127:0]   data_d [8];

    logic [2:0]     addr_tag;
    logic [2:0]     addr_idx;
    logic [1:0]     addr_word;
    logic           hit;
    logic           fill;
    logic           busy;
    logic           mem_read;
    logic [127:0]   line;
    logic           unused_byte_bits;

    assign addr_tag  = bus.ADDRESS[9:7];
    assign addr_idx  = bus.ADDRESS[6:4];
    assign addr_word = bus.ADDRESS[3:2];
    assign unused_byte_bits = ^bus.ADDRESS[1:0];

    assign hit  = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    // The fill is indexed only by the latched miss address, so the PC may
    // wander during a miss without affecting which line gets written.
    assign fill = (state_q == READ_MEM) && !bus.MEM_BUSYWAIT;

    assign line            = data_q[addr_idx];
    assign bus.INSTRUCTION = line[{addr_word, 5'b0} +: 32];
    assign bus.MEM_ADDRESS = miss_q;
    // Reset must drop both outputs immediately, not at the next edge.
    assign bus.BUSYWAIT    = busy && !RESET;
    assign bus.MEM_READ    = mem_read && !RESET;

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        valid_d  = valid_q;
        busy     = 1'b0;
        mem_read = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = !hit;
                if (!hit) begin
                    miss_d  = bus.ADDRESS[9:4];
                    state_d = READ_MEM;
                end
            end
            READ_MEM: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    valid_d[miss_q[2:0]] = 1'b1;
                    state_d              = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tag_d  = tag_q;
        data_d = data_q;
        if (fill) begin
            tag_d[miss_q[2:0]]  = miss_q[5:3];
            data_d[miss_q[2:0]] = bus.MEM_READDATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            miss_q  <= 6'd0;
            valid_q <= 8'd0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            valid_q <= valid_d;
        end
    end

    // Tag and data contents are qualified by valid_q and need no reset.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_icache_unit.sv
module tb_icache_unit;
    logic CLK;
    logic RESET;
    icache_unit_if bus();

    icache_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Instruction memory image and responder latency.
    logic [127:0] mem_blk [64];
    int           mem_lat = 4;

    // Reference cache state: which block is resident in each line.
    bit           ref_valid [8];
    logic [2:0]   ref_tag   [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [9:0] a);
        logic [127:0] blk;
        blk = mem_blk[a[9:4]];
        return blk[{a[3:2], 5'b0} +: 32];
    endfunction

    // Memory responder: busy for mem_lat cycles of a read, then ready.
    initial begin
        int cnt;
        cnt = 0;
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = '0;
        forever begin
            @(negedge CLK);
            if (RESET || bus.MEM_READ !== 1'b1) begin
                cnt = 0;
                bus.MEM_BUSYWAIT = 1'b0;
            end else begin
                bus.MEM_BUSYWAIT = (cnt < mem_lat);
                cnt++;
            end
            bus.MEM_READDATA = mem_blk[bus.MEM_ADDRESS];
        end
    end

    // One fetch from the current (post-edge) point until the instruction is delivered.
    task automatic access(input logic [9:0] a);
        int  busy_cyc;
        int  rd_cyc;
        bit  hit;
        hit = ref_valid[a[6:4]] && (ref_tag[a[6:4]] == a[9:7]);
        busy_cyc = 0;
        rd_cyc   = 0;
        bus.ADDRESS = a;
        @(negedge CLK);
        while (bus.BUSYWAIT === 1'b1 && busy_cyc < 200) begin
            busy_cyc++;
            if (bus.MEM_READ === 1'b1) begin
                rd_cyc++;
                check("mem_address", 32'(bus.MEM_ADDRESS), 32'(a[9:4]));
            end
            @(negedge CLK);
        end
        check("busy_cycles", busy_cyc, hit ? 0 : mem_lat + 3);
        check("mem_read_cycles", rd_cyc, hit ? 0 : mem_lat + 1);
        check("mem_read_idle", 32'(bus.MEM_READ), 32'd0);
        check("instruction", bus.INSTRUCTION, word_of(a));
        ref_valid[a[6:4]] = 1'b1;
        ref_tag[a[6:4]]   = a[9:7];
        @(posedge CLK); #1;
    endtask

    initial begin
        int          cyc;
        logic [5:0]  req_q[$];
        bit          prev_rd;
        logic [9:0]  a;

        for (int i = 0; i < 64; i++)
            mem_blk[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 3'd0;
        end

        // Reset state: outputs quiet while RESET is high.
        RESET = 1'b1;
        bus.ADDRESS = 10'h000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busywait", 32'(bus.BUSYWAIT), 32'd0);
        check("rst_mem_read", 32'(bus.MEM_READ), 32'd0);
        check("rst_mem_address", 32'(bus.MEM_ADDRESS), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        // First fill with L = 4, then sequential hits across the line.
        mem_lat = 4;
        access(10'h000);
        access(10'h004);
        access(10'h008);
        access(10'h00C);

        // Conflict misses on index 0.
        access(10'h080);
        access(10'h000);

        // Address moves from 0x010 to 0x020 while the 0x010 fill is in flight.
        mem_lat = 3;
        bus.ADDRESS = 10'h010;
        cyc = 0;
        prev_rd = 1'b0;
        @(negedge CLK);
        while (bus.BUSYWAIT === 1'b1 && cyc < 200) begin
            if (bus.MEM_READ === 1'b1 && !prev_rd) req_q.push_back(bus.MEM_ADDRESS);
            prev_rd = (bus.MEM_READ === 1'b1);
            cyc++;
            if (cyc == 2) bus.ADDRESS = 10'h020;
            @(negedge CLK);
        end
        check("chg_busy_cycles", cyc, 2 * (mem_lat + 3));
        check("chg_req_count", req_q.size(), 2);
        if (req_q.size() == 2) begin
            check("chg_first_addr", 32'(req_q[0]), 32'h01);
            check("chg_second_addr", 32'(req_q[1]), 32'h02);
        end
        check("chg_instruction", bus.INSTRUCTION, word_of(10'h020));
        ref_valid[1] = 1'b1; ref_tag[1] = 3'd0;
        ref_valid[2] = 1'b1; ref_tag[2] = 3'd0;
        @(posedge CLK); #1;
        access(10'h014);

        // Reset two cycles into READ_MEM.
        mem_lat = 4;
        bus.ADDRESS = 10'h300;
        @(posedge CLK); #1;
        check("mid_mem_read_up", 32'(bus.MEM_READ), 32'd1);
        @(posedge CLK); #2;
        RESET = 1'b1;
        #1;
        check("mid_rst_mem_read", 32'(bus.MEM_READ), 32'd0);
        check("mid_rst_busywait", 32'(bus.BUSYWAIT), 32'd0);
        check("mid_rst_mem_address", 32'(bus.MEM_ADDRESS), 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        access(10'h000);
        access(10'h300);

        // Zero-latency memory.
        mem_lat = 0;
        access(10'h3F0);
        access(10'h3F8);

        // Randomized fetches, biased to two tags so hits and conflicts both occur.
        for (int n = 0; n < 40; n++) begin
            mem_lat = $urandom_range(0, 5);
            a[6:0] = 7'($urandom);
            a[9:7] = 3'($urandom_range(0, 1));
            access(a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
